cache_arbiter: RTL and testbench

- Shares the single physical-memory port (cacheline adaptor side, 256-bit lines) between the instruction cache and the data cache.
- Sits between both cache controllers' pmem_* interfaces and the memory/adaptor.
- Grants one requester at a time and holds the grant until that transaction's mem_resp.
- Breaks ties round-robin so that neither cache starves.

---
 rtl/cache_types_pkg.sv | 18 +
 rtl/cache_arbiter.sv | 108 ++++++++++
 tb/tb_cache_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Types and widths shared by the caches, the cacheline adaptor and the memory arbiter.
package cache_types_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache; grant held until mem_resp,
// round-robin on ties, one-cycle IDLE bubble before each grant, memory strobes forwarded combinationally.
module cache_arbiter #(
  parameter int ADDR_W = cache_types_pkg::ADDR_W,
  parameter int LINE_W = cache_types_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  import cache_types_pkg::*;

  arb_state_t r_state;
  requester_t r_last_grant;
  logic       w_i_req;
  logic       w_d_req;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  // last_grant resets to I so that the D-cache wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req && w_d_req)
            r_state <= (r_last_grant == REQ_I) ? SERVE_D : SERVE_I;
          else if (w_i_req)
            r_state <= SERVE_I;
          else if (w_d_req)
            r_state <= SERVE_D;
        end
        SERVE_I: begin
          if (mem_resp) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_D;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset kills the forward in the same cycle so an aborted grant never leaks a resp.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    if (!rst) begin
      case (r_state)
        SERVE_I: begin
          mem_read    = i_pmem_read;
          mem_address = i_pmem_address;
          i_pmem_resp = mem_resp;
        end
        SERVE_D: begin
          mem_read    = d_pmem_read;
          mem_write   = d_pmem_write;
          mem_address = d_pmem_address;
          mem_wdata   = d_pmem_wdata;
          d_pmem_resp = mem_resp;
        end
        default: ;
      endcase
    end
  end

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  a_d_read_write_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_pmem_read && d_pmem_write));

  a_i_holds_request: assert property (@(posedge clk) disable iff (rst)
    (r_state == SERVE_I) |-> i_pmem_read);

  a_d_holds_request: assert property (@(posedge clk) disable iff (rst)
    (r_state == SERVE_D) |-> (d_pmem_read || d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant order, bubble timing, resp routing, reset abort.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_tests;
  int n_fail;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_dead;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    i_pmem_read = 1'b1;
    #1;
    n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %0b exp 0", mem_read); end
    n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %0b exp 0", mem_write); end
    n_tests++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address got %h exp 0", mem_address); end
    n_tests++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL reset_resp got %b exp 00", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    i_pmem_read = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_tie_after_reset();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2000;
    #1;
    n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL tie_bubble mem_read got %0b exp 0", mem_read); end
    @(negedge clk); #1;
    n_tests++; if (mem_address !== 32'h2000 || mem_read !== 1'b1) begin n_fail++; $display("FAIL tie_first_d addr %h rd %0b exp 2000 1", mem_address, mem_read); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL tie_d_resp got %b exp 01", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_read = 1'b0; #1;
    n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL tie_mid_bubble mem_read got %0b exp 0", mem_read); end
    @(negedge clk); #1;
    n_tests++; if (mem_address !== 32'h1000 || mem_read !== 1'b1) begin n_fail++; $display("FAIL tie_second_i addr %h rd %0b exp 1000 1", mem_address, mem_read); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL tie_i_resp got %b exp 10", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
  endtask

  task automatic test_i_only();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000; #1;
    n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL i_only_bubble mem_read got %0b exp 0", mem_read); end
    @(negedge clk); #1;
    n_tests++; if (mem_read !== 1'b1 || mem_address !== 32'h1000 || mem_write !== 1'b0) begin n_fail++; $display("FAIL i_only_fwd rd %0b wr %0b addr %h exp 1 0 1000", mem_read, mem_write, mem_address); end
    n_tests++; if (i_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL i_only_early_resp got %0b exp 0", i_pmem_resp); end
    repeat (2) @(negedge clk);
    mem_resp = 1'b1; mem_rdata = pat_a5; #1;
    n_tests++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL i_only_resp i %0b d %0b exp 1 0", i_pmem_resp, d_pmem_resp); end
    n_tests++; if (i_pmem_rdata !== pat_a5) begin n_fail++; $display("FAIL i_only_rdata got %h exp %h", i_pmem_rdata, pat_a5); end
    n_tests++; if (d_pmem_rdata !== pat_a5) begin n_fail++; $display("FAIL i_only_broadcast got %h exp %h", d_pmem_rdata, pat_a5); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0; #1;
    n_tests++; if (i_pmem_resp !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL i_only_after resp %0b rd %0b exp 0 0", i_pmem_resp, mem_read); end
  endtask

  task automatic test_alternation();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      logic        exp_d;
      logic [31:0] exp_addr;
      exp_d    = (k % 2 == 0);
      exp_addr = exp_d ? 32'h2000 : 32'h1000;
      @(negedge clk);
      mem_resp = 1'b1; #1;
      n_tests++; if (mem_address !== exp_addr) begin n_fail++; $display("FAIL alt_addr[%0d] got %h exp %h", k, mem_address, exp_addr); end
      n_tests++; if ({i_pmem_resp, d_pmem_resp} !== {~exp_d, exp_d}) begin n_fail++; $display("FAIL alt_resp[%0d] got %b exp %b", k, {i_pmem_resp, d_pmem_resp}, {~exp_d, exp_d}); end
      @(negedge clk);
      mem_resp = 1'b0; #1;
      n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL alt_bubble[%0d] mem_read got %0b exp 0", k, mem_read); end
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_3000; d_pmem_wdata = pat_dead;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000; #1;
    n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble mem_write got %0b exp 0", mem_write); end
    @(negedge clk); #1;
    n_tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h3000) begin n_fail++; $display("FAIL b2b_wb wr %0b rd %0b addr %h exp 1 0 3000", mem_write, mem_read, mem_address); end
    n_tests++; if (mem_wdata !== pat_dead) begin n_fail++; $display("FAIL b2b_wdata got %h exp %h", mem_wdata, pat_dead); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL b2b_wb_resp got %b exp 01", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h0000_4000; #1;
    n_tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_wdata !== '0) begin n_fail++; $display("FAIL b2b_idle rd %0b wr %0b wdata %h exp 0 0 0", mem_read, mem_write, mem_wdata); end
    @(negedge clk); #1;
    n_tests++; if (mem_address !== 32'h1000 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_wdata !== '0) begin n_fail++; $display("FAIL b2b_i_wins addr %h rd %0b wr %0b wdata %h exp 1000 1 0 0", mem_address, mem_read, mem_write, mem_wdata); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL b2b_i_resp got %b exp 10", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (mem_address !== 32'h4000 || mem_read !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL b2b_d_read addr %h rd %0b wr %0b exp 4000 1 0", mem_address, mem_read, mem_write); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL b2b_d_resp got %b exp 01", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2000;
    @(negedge clk); #1;
    n_tests++; if (mem_read !== 1'b1 || mem_address !== 32'h2000) begin n_fail++; $display("FAIL rmid_serving rd %0b addr %h exp 1 2000", mem_read, mem_address); end
    rst = 1'b1; mem_resp = 1'b1; #1;
    n_tests++; if (d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resp got %0b exp 0", d_pmem_resp); end
    @(negedge clk);
    rst = 1'b0; mem_resp = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000; #1;
    n_tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL rmid_idle rd %0b wr %0b dresp %0b exp 0 0 0", mem_read, mem_write, d_pmem_resp); end
    @(negedge clk); #1;
    n_tests++; if (mem_address !== 32'h2000 || mem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_tie_d addr %h rd %0b exp 2000 1", mem_address, mem_read); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL rmid_d_resp got %b exp 01", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_read = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (mem_address !== 32'h1000 || mem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_then_i addr %h rd %0b exp 1000 1", mem_address, mem_read); end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL stray_resp got %b exp 00", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; #1;
    n_tests++; if (mem_read !== 1'b0 || mem_address !== 32'h0) begin n_fail++; $display("FAIL stray_idle rd %0b addr %h exp 0 0", mem_read, mem_address); end
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_5000;
    @(negedge clk); #1;
    n_tests++; if (mem_read !== 1'b1 || mem_address !== 32'h5000) begin n_fail++; $display("FAIL stray_next_grant rd %0b addr %h exp 1 5000", mem_read, mem_address); end
    mem_resp = 1'b1; #1;
    n_tests++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL stray_next_resp got %b exp 10", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pat_a5   = {8{32'hA5A5_A5A5}};
    pat_dead = {8{32'hDEAD_BEEF}};
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;

    test_reset();
    test_tie_after_reset();
    test_i_only();
    test_alternation();
    test_back_to_back();
    test_reset_mid();
    test_stray_resp();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
